video_in_capture: RTL and testbench

VIDEO_IN_CAPTURE -- requirements
Module: video_in_capture

---
 rtl/video_in_capture.sv | 139 +++++++++++++
 tb/tb_video_in_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/video_in_capture.sv
// Video input capture: registers a sync/blank/RGB stream, measures its
// geometry and forwards pixel coordinates once HDISP x VDISP is locked.
module video_in_capture #(
    parameter int HDISP = 800,
    parameter int VDISP = 480
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic        vid_blank,
    input  logic [23:0] vid_rgb,
    output logic        pix_valid,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic [23:0] pix_rgb,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        locked,
    output logic [11:0] meas_h,
    output logic [11:0] meas_v,
    output logic [7:0]  err_count
);

    localparam logic [11:0] HD    = 12'(HDISP);
    localparam logic [11:0] VD    = 12'(VDISP);
    localparam logic [11:0] HLAST = 12'(HDISP - 1);
    localparam logic [11:0] CMAX  = 12'hFFF;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t      state, state_nx;
    logic        hs_r, vs_r, blank_r;
    logic [23:0] rgb_r;
    logic        vs_p, blank_p;
    logic [11:0] col, row;

    logic        fs, ls, le;
    logic [11:0] col_cur, row_cur;
    logic        v_pix, v_short, v_extra, v_fsmid, v_hs;
    logic        v_any, v_lock;
    logic        err_inc, accept;

    always_comb begin
        fs      = vs_p & ~vs_r;
        ls      = ~blank_p & blank_r;
        le      = blank_p & ~blank_r;
        col_cur = ls ? 12'd0 : col;
        row_cur = fs ? 12'd0 : row;
        v_pix   = blank_r && (col_cur == HD);
        v_short = le && (col < HD);
        v_extra = ls && (row_cur == VD);
        // a frame start that lands on a line start is legal (row 0)
        v_fsmid = fs && blank_r && blank_p;
        v_hs    = blank_r && !hs_r;
        v_any   = v_pix | v_short | v_extra | v_fsmid | v_hs;
        v_lock  = v_any | (fs && (row != VD));
    end

    always_comb begin
        state_nx = state;
        err_inc  = 1'b0;
        unique case (state)
            SEARCH: begin
                if (fs) state_nx = MEASURE;
            end
            MEASURE: begin
                if (v_any)
                    state_nx = SEARCH;
                else if (fs)
                    state_nx = (row == VD) ? LOCKED : SEARCH;
            end
            LOCKED: begin
                if (v_lock) begin
                    state_nx = SEARCH;
                    err_inc  = 1'b1;
                end
            end
            default: state_nx = SEARCH;
        endcase
        accept = (state_nx == LOCKED) && blank_r;
    end

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            state     <= SEARCH;
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
            blank_r   <= 1'b0;
            rgb_r     <= '0;
            vs_p      <= 1'b1;
            blank_p   <= 1'b0;
            col       <= '0;
            row       <= '0;
            meas_h    <= '0;
            meas_v    <= '0;
            err_count <= '0;
            locked    <= 1'b0;
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            state   <= state_nx;
            hs_r    <= vid_hs;
            vs_r    <= vid_vs;
            blank_r <= vid_blank;
            rgb_r   <= vid_rgb;
            vs_p    <= vs_r;
            blank_p <= blank_r;
            if (blank_r)
                col <= (col_cur == CMAX) ? col_cur : col_cur + 12'd1;
            if (fs)
                row <= '0;
            else if (le && row != CMAX)
                row <= row + 12'd1;
            if (le) meas_h <= col;
            if (fs) meas_v <= row;
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            locked    <= (state_nx == LOCKED);
            pix_valid <= accept;
            pix_sof   <= accept && col_cur == 12'd0 && row_cur == 12'd0;
            pix_eol   <= accept && col_cur == HLAST;
            if (accept) begin
                pix_x   <= col_cur;
                pix_y   <= row_cur;
                pix_rgb <= rgb_r;
            end
        end
    end

endmodule

// File: tb/tb_video_in_capture.sv
// Bench for video_in_capture: directed frames with a pixel scoreboard
// and point checks of lock, error counter and measurements.
module tb_video_in_capture;

    localparam int HD = 12;
    localparam int VD = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_hs, vid_vs, vid_blank;
    logic [23:0] vid_rgb;
    logic        pix_valid, pix_sof, pix_eol, locked;
    logic [11:0] pix_x, pix_y, meas_h, meas_v;
    logic [23:0] pix_rgb;
    logic [7:0]  err_count;

    video_in_capture #(.HDISP(HD), .VDISP(VD)) dut (
        .pixel_clk  (clk),
        .pixel_rst_n(rst_n),
        .vid_hs     (vid_hs),
        .vid_vs     (vid_vs),
        .vid_blank  (vid_blank),
        .vid_rgb    (vid_rgb),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .locked     (locked),
        .meas_h     (meas_h),
        .meas_v     (meas_v),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
        bit          sof;
        bit          eol;
        int          t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   emit;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (pix_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d, required no pixel",
                         pix_x, pix_y);
            end else begin
                e = q.pop_front();
                if (int'(pix_x) != e.x || int'(pix_y) != e.y ||
                    pix_rgb !== e.rgb || pix_sof !== e.sof ||
                    pix_eol !== e.eol || cyc != e.t) begin
                    failures++;
                    $display("FAIL pix: got x=%0d y=%0d rgb=%h sof=%b eol=%b t=%0d, required x=%0d y=%0d rgb=%h sof=%b eol=%b t=%0d",
                             pix_x, pix_y, pix_rgb, pix_sof, pix_eol, cyc,
                             e.x, e.y, e.rgb, e.sof, e.eol, e.t);
                end
            end
        end else if (pix_sof || pix_eol) begin
            checks++;
            failures++;
            $display("FAIL qual_idle: got sof=%b eol=%b, required 0 0",
                     pix_sof, pix_eol);
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic put(input bit vs, input bit hs, input bit bl,
                       input logic [23:0] rgb, input bit rn);
        vid_vs    = vs;
        vid_hs    = hs;
        vid_blank = bl;
        vid_rgb   = rgb;
        rst_n     = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int y, input int n, input bit hsg,
                        input bit co, input int rstx);
        exp_t e;
        logic [23:0] rgb;
        for (int x = 0; x < n; x++) begin
            rgb = {8'(y), 8'hA5, 8'(x)};
            if (x == HD || (hsg && x == 3) || (x == 0 && y >= VD) ||
                (rstx >= 0 && x >= rstx - 1))
                emit = 0;
            if (emit) begin
                e = '{x: x, y: y, rgb: rgb, sof: (x == 0 && y == 0),
                      eol: (x == HD - 1), t: cyc + 2};
                q.push_back(e);
            end
            put(!(co && x < 2), !(hsg && x == 3), 1'b1, rgb, x != rstx);
            if (x == rstx) begin
                chk("rst_valid", int'(pix_valid), 0);
                chk("rst_locked", int'(locked), 0);
                chk("rst_err", int'(err_count), 0);
                chk("rst_meas_h", int'(meas_h), 0);
                chk("rst_pix_x", int'(pix_x), 0);
                chk("rst_pix_rgb", int'(pix_rgb), 0);
            end
        end
        if (n < HD) emit = 0;
        put(1, 1, 0, 0, 1);
        put(1, 0, 0, 0, 1);
        put(1, 1, 0, 0, 1);
        put(1, 1, 0, 0, 1);
    endtask

    task automatic frame(input int nl, input int longl, input int shortl,
                         input int hsl, input bit co, input int rst_line,
                         input int chk_lock);
        int n;
        for (int i = 0; i < 5; i++)
            put(co || i >= 2, 1, 0, 0, 1);
        if (chk_lock >= 0) chk("frame_lock", int'(locked), chk_lock);
        for (int y = 0; y < nl; y++) begin
            n = (y == longl) ? HD + 1 : (y == shortl) ? HD - 1 : HD;
            line(y, n, y == hsl, co && y == 0, (y == rst_line) ? 5 : -1);
        end
    endtask

    initial begin
        emit = 0;
        for (int i = 0; i < 3; i++) put(1, 1, 0, 0, 0);
        chk("reset_valid", int'(pix_valid), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_err", int'(err_count), 0);
        chk("reset_meas_h", int'(meas_h), 0);
        chk("reset_meas_v", int'(meas_v), 0);
        chk("reset_pix_y", int'(pix_y), 0);
        put(1, 1, 0, 0, 1);
        put(1, 1, 0, 0, 1);

        emit = 0; frame(VD, -1, -1, -1, 0, -1, 0);
        chk("first_frame_unlocked", int'(locked), 0);
        emit = 1; frame(VD, -1, -1, -1, 0, -1, 1);
        emit = 1; frame(VD, -1, -1, -1, 1, -1, -1);
        chk("co_locked", int'(locked), 1);
        chk("meas_h", int'(meas_h), HD);
        chk("meas_v", int'(meas_v), VD);

        emit = 1; frame(VD, 2, -1, -1, 0, -1, 1);
        chk("long_locked", int'(locked), 0);
        chk("long_err", int'(err_count), 1);
        emit = 0; frame(VD, -1, -1, -1, 0, -1, 0);
        emit = 1; frame(VD, -1, -1, -1, 0, -1, 1);

        emit = 1; frame(VD - 1, -1, -1, -1, 0, -1, 1);
        emit = 0; frame(VD, -1, -1, -1, 0, -1, 0);
        chk("short_frame_err", int'(err_count), 2);
        chk("short_frame_meas_v", int'(meas_v), VD - 1);

        emit = 0; frame(VD, -1, -1, -1, 0, -1, 0);
        emit = 1; frame(VD, -1, -1, -1, 0, 3, 1);
        emit = 0; frame(VD, -1, -1, -1, 0, -1, 0);
        emit = 1; frame(VD, -1, -1, -1, 0, -1, 1);

        put(1, 1, 0, 0, 0);
        put(1, 1, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            emit = 0; frame(VD, -1, -1, -1, 0, -1, 0);
            emit = 1;
            frame(1, (i % 3 == 0) ? 0 : -1, (i % 3 == 1) ? 0 : -1,
                  (i % 3 == 2) ? 0 : -1, 0, -1, 1);
            if (i == 0) chk("sat_first_err", int'(err_count), 1);
            if (i == 254) chk("sat_255_err", int'(err_count), 255);
        end
        for (int i = 0; i < 4; i++) put(1, 1, 0, 0, 1);
        chk("sat_err", int'(err_count), 255);
        chk("sat_locked", int'(locked), 0);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
